equiv_check_engine: RTL and testbench
=====================================

Name: equiv_check_engine

Overview:
- Synthesizable on-chip counterpart of the golden-vs-post-route simulation benches.
- Generates stimulus for two copies of a small combinational DUT (golden RTL and post-route netlist) and samples both responses.
- Counts mismatches and reports pass/fail, so equivalence runs on hardware or emulation without a simulator-side checker.
- Sequence: exhaustive directed vectors, then LFSR pseudo-random vectors.

Parameters:
- IN_W, 2, stimulus width (1..16).
- OUT_W, 1, DUT output width.
- NUM_RANDOM, 500, number of random vectors after the directed sweep.
- SETTLE_CYCLES, 2, cycles each vector is held before compare (>=1).
- LFSR_SEED, 16'hACE1, LFSR reset/restart value (must be nonzero).
- MISMATCH_W, 16, width of the saturating mismatch counter.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begin a run; sampled only in IDLE or DONE.
- stim, output, IN_W, stimulus driven to both DUT copies.
- golden_in, input, OUT_W, golden DUT response.
- netlist_in, input, OUT_W, netlist DUT response.
- busy, output, 1, run in progress.
- done, output, 1, run complete; held until next start.
- pass, output, 1, done with zero mismatches.
- mismatch_count, output, MISMATCH_W, saturating mismatch count.
- vector_count, output, 32, vectors compared in the current run.
- first_fail_vec, output, IN_W, stim of the first mismatching vector.
- first_fail_valid, output, 1, first_fail_vec holds a captured value.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-high.
- Reset (async): state IDLE. All outputs 0 (stim, busy, done, pass, mismatch_count, vector_count, first_fail_vec, first_fail_valid). LFSR = LFSR_SEED. phase = 0.
- FSM states: IDLE, DIRECTED, RANDOM, DONE.
- IDLE/DONE with start=1 at an edge:
  - next cycle: state DIRECTED, busy=1, done=0, pass=0.
  - counters and first_fail cleared, LFSR reloaded with LFSR_SEED.
  - stim=0, phase=0.
- start while busy is ignored.
- Per vector:
  - stim is held for phases 0..SETTLE_CYCLES.
  - At the edge where phase==SETTLE_CYCLES, golden_in and netlist_in are sampled and compared bitwise; any differing bit is a mismatch.
  - Each vector takes SETTLE_CYCLES+1 cycles.
- On each compare:
  - vector_count += 1.
  - On mismatch: mismatch_count += 1, saturating at all-ones.
  - If first_fail_valid=0 on a mismatch: capture stim into first_fail_vec and set first_fail_valid=1.
  - Then phase=0 and the next vector is applied on the following cycle.
- DIRECTED: stim = 0, 1, ..., 2^IN_W-1 (stim[0]=a, stim[1]=b for 2-input DUTs). After the last compare, go to RANDOM. If NUM_RANDOM=0, go directly to DONE.
- RANDOM:
  - 16-bit Galois LFSR, right shift, tap mask 16'hB400 (applied when the shifted-out LSB is 1).
  - stim = lfsr[IN_W-1:0]; the first random stim uses LFSR_SEED.
  - LFSR advances once per compare.
  - After NUM_RANDOM compares, go to DONE.
- DONE: busy=0, done=1, pass=(mismatch_count==0), registered in the same cycle. stim holds its last value. Results are held until start or rst.
- Total busy cycles = (2^IN_W + NUM_RANDOM)*(SETTLE_CYCLES+1).
- Reset mid-run: immediate abort to the reset values; no partial result retained.
- Simultaneous start and rst: rst wins.

Decomposition:
- Package equiv_check_pkg holds:
  - state_t enum {IDLE, DIRECTED, RANDOM, DONE}.
  - LFSR_TAPS = 16'hB400.
  - DEFAULT_SEED = 16'hACE1.
- One sub-module, lfsr16:
  - inputs: clk, rst, load, seed, advance.
  - output: value.
  - Same async active-high reset.
- FSM, phase counter and result registers stay in equiv_check_engine.

Test Plan:
All scenarios use IN_W=2, OUT_W=1, SETTLE_CYCLES=2, NUM_RANDOM=4, and golden = OR of stim bits unless stated.
1. Matching netlist = golden, start pulsed one cycle:
   - busy=1 next cycle.
   - stim sequence: 0,1,2,3 (3 cycles each), then 1,0,0,0 (LFSR values ACE1, E270, 7138, 389C).
   - done=1 after 24 busy cycles; pass=1, mismatch_count=0, vector_count=8.
2. Netlist stuck at 0:
   - mismatches on stim 1, 2, 3 and random vector 1 → mismatch_count=4, pass=0.
   - first_fail_vec=1, first_fail_valid=1.
3. Netlist = golden, but forced wrong only when stim=2 → mismatch_count=1, first_fail_vec=2, pass=0.
4. rst asserted asynchronously at cycle 10 of a run:
   - all outputs 0 immediately, with no clock edge needed.
   - a subsequent start reruns cleanly to the scenario 1 result.
5. start pulsed repeatedly while busy → no effect, same timing as scenario 1.
   - start pulsed in DONE → counters cleared, run repeats identically.
6. MISMATCH_W=2, netlist = ~golden (8 mismatches) → mismatch_count saturates at 3, vector_count=8, pass=0.

Source files
------------

// File: rtl/equiv_check_pkg.sv
// Shared types and constants for the on-chip golden-vs-netlist equivalence engine.
package equiv_check_pkg;

  typedef enum logic [1:0] {IDLE, DIRECTED, RANDOM, DONE} state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/equiv_check_engine_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and advance; async reset to RESET_SEED.
module lfsr16
  import equiv_check_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)         value_d = seed;
    else if (advance) value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= RESET_SEED;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/equiv_check_engine.sv
// Drives exhaustive then pseudo-random vectors into golden and netlist DUT copies,
// compares their settled responses and reports mismatch statistics.
module equiv_check_engine
  import equiv_check_pkg::*;
#(
  parameter int          IN_W          = 2,
  parameter int          OUT_W         = 1,
  parameter int          NUM_RANDOM    = 500,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
  parameter int          MISMATCH_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IN_W-1:0]       stim,
  input  logic [OUT_W-1:0]      golden_in,
  input  logic [OUT_W-1:0]      netlist_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [MISMATCH_W-1:0] mismatch_count,
  output logic [31:0]           vector_count,
  output logic [IN_W-1:0]       first_fail_vec,
  output logic                  first_fail_valid
);

  localparam int              PH_W      = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SETTLE_CYCLES);
  localparam logic [IN_W-1:0] STIM_MAX  = '1;
  localparam logic [31:0]     RAND_LAST = 32'(NUM_RANDOM - 1);

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [IN_W-1:0]        stim_q, stim_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [MISMATCH_W-1:0]  mm_q, mm_d, mm_new;
  logic [31:0]            vc_q, vc_d;
  logic [31:0]            rnd_q, rnd_d;
  logic [IN_W-1:0]        ff_vec_q, ff_vec_d;
  logic                   ff_valid_q, ff_valid_d;

  logic        lfsr_load, lfsr_adv;
  logic [15:0] lfsr_value, lfsr_next;
  logic        mismatch, cmp_now, finish_run;
  logic        unused_lfsr;

  lfsr16 #(
    .RESET_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  assign lfsr_next   = lfsr_step(lfsr_value);
  assign unused_lfsr = ^{lfsr_value, lfsr_next};

  assign mismatch = |(golden_in ^ netlist_in);
  assign cmp_now  = ((state_q == DIRECTED) || (state_q == RANDOM)) && (phase_q == PH_LAST);
  // Counter sticks at all-ones rather than wrapping back to a passing-looking value.
  assign mm_new   = (mismatch && (mm_q != '1)) ? mm_q + 1'b1 : mm_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mm_d       = mm_q;
    vc_d       = vc_q;
    rnd_d      = rnd_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;
    finish_run = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = DIRECTED;
          phase_d    = '0;
          stim_d     = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          mm_d       = '0;
          vc_d       = '0;
          rnd_d      = '0;
          ff_vec_d   = '0;
          ff_valid_d = 1'b0;
          lfsr_load  = 1'b1;
        end
      end
      DIRECTED, RANDOM: begin
        if (!cmp_now) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          vc_d    = vc_q + 32'd1;
          mm_d    = mm_new;
          if (mismatch && !ff_valid_q) begin
            ff_vec_d   = stim_q;
            ff_valid_d = 1'b1;
          end
          if (state_q == DIRECTED) begin
            if (stim_q != STIM_MAX) begin
              stim_d = stim_q + 1'b1;
            end else if (NUM_RANDOM == 0) begin
              finish_run = 1'b1;
            end else begin
              // LFSR is untouched during the sweep, so it still holds the seed here.
              state_d = RANDOM;
              stim_d  = lfsr_value[IN_W-1:0];
            end
          end else begin
            lfsr_adv = 1'b1;
            rnd_d    = rnd_q + 32'd1;
            if (rnd_q == RAND_LAST) finish_run = 1'b1;
            else                    stim_d = lfsr_next[IN_W-1:0];
          end
          if (finish_run) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mm_new == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mm_q       <= '0;
      vc_q       <= '0;
      rnd_q      <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      mm_q       <= mm_d;
      vc_q       <= vc_d;
      rnd_q      <= rnd_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign vector_count     = vc_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_equiv_check_engine.sv
// Bench for equiv_check_engine: OR-gate golden model with selectable netlist faults.
module tb_equiv_check_engine;

  localparam int IN_W       = 2;
  localparam int OUT_W      = 1;
  localparam int NUM_RANDOM = 4;
  localparam int SETTLE     = 2;
  localparam int NVEC       = (1 << IN_W) + NUM_RANDOM;
  localparam int BUSY_CYC   = NVEC * (SETTLE + 1);

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [IN_W-1:0]  stim, stim2;
  logic [OUT_W-1:0] golden_in, netlist_in, golden2, netlist2;
  logic             busy, done, pass, busy2, done2, pass2;
  logic [15:0]      mismatch_count;
  logic [1:0]       mismatch_count2;
  logic [31:0]      vector_count, vector_count2;
  logic [IN_W-1:0]  first_fail_vec, first_fail_vec2;
  logic             first_fail_valid, first_fail_valid2;

  int         mode;
  logic [3:0] fault_map;

  int n_pass  = 0;
  int n_total = 0;

  logic [IN_W-1:0] exp_vec[$];
  logic [IN_W-1:0] trace[$];
  int   busy_cycles;
  logic obs_busy_first, obs_done_first, obs_ffv_first;
  logic [31:0] obs_vc_first;
  logic [15:0] obs_mm_first;

  always #5 clk = ~clk;

  always_comb begin
    golden_in = |stim;
    case (mode)
      1:       netlist_in = 1'b0;
      2:       netlist_in = (stim == 2'd2) ? ~golden_in : golden_in;
      3:       netlist_in = golden_in ^ fault_map[stim];
      default: netlist_in = golden_in;
    endcase
  end

  assign golden2  = |stim2;
  assign netlist2 = ~golden2;

  equiv_check_engine #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_RANDOM(NUM_RANDOM), .SETTLE_CYCLES(SETTLE),
    .LFSR_SEED(16'hACE1), .MISMATCH_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim),
    .golden_in(golden_in), .netlist_in(netlist_in),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mismatch_count), .vector_count(vector_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  equiv_check_engine #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_RANDOM(NUM_RANDOM), .SETTLE_CYCLES(SETTLE),
    .LFSR_SEED(16'hACE1), .MISMATCH_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stim(stim2),
    .golden_in(golden2), .netlist_in(netlist2),
    .busy(busy2), .done(done2), .pass(pass2),
    .mismatch_count(mismatch_count2), .vector_count(vector_count2),
    .first_fail_vec(first_fail_vec2), .first_fail_valid(first_fail_valid2)
  );

  // Reference: vector order is the exhaustive sweep followed by LFSR low bits.
  task automatic build_model();
    logic [15:0] l;
    exp_vec.delete();
    for (int i = 0; i < (1 << IN_W); i++) exp_vec.push_back(IN_W'(i));
    l = 16'hACE1;
    for (int k = 0; k < NUM_RANDOM; k++) begin
      exp_vec.push_back(l[IN_W-1:0]);
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  function automatic bit is_fault(input int m, input int v);
    bit g, n;
    g = (v != 0);
    case (m)
      1:       n = 1'b0;
      2:       n = (v == 2) ? !g : g;
      3:       n = g ^ fault_map[v];
      4:       n = !g;
      default: n = g;
    endcase
    return g != n;
  endfunction

  function automatic void model(input int m, input int sat_max,
                                output int mm, output int first, output bit ffv);
    mm = 0; first = 0; ffv = 1'b0;
    foreach (exp_vec[i]) begin
      if (is_fault(m, int'(exp_vec[i]))) begin
        if (mm < sat_max) mm++;
        if (!ffv) begin ffv = 1'b1; first = int'(exp_vec[i]); end
      end
    end
  endfunction

  task automatic do_run(input bit pulse_busy);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    obs_busy_first = busy;
    obs_done_first = done;
    obs_vc_first   = vector_count;
    obs_mm_first   = mismatch_count;
    obs_ffv_first  = first_fail_valid;
    trace.delete();
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 4 * BUSY_CYC) begin
      trace.push_back(stim);
      busy_cycles++;
      if (pulse_busy) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({stim, busy, done, pass, mismatch_count, vector_count, first_fail_vec, first_fail_valid} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b mm=%0d vc=%0d want all 0",
               busy, done, pass, mismatch_count, vector_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, pass} !== 3'b000)
      $display("FAIL reset_idle_hold: got busy=%b done=%b pass=%b want 000", busy, done, pass);
    else n_pass++;
  endtask

  task automatic test_match();
    mode = 0;
    do_run(1'b0);
    n_total++;
    if (obs_busy_first !== 1'b1) $display("FAIL match_busy_next: got %b want 1", obs_busy_first);
    else n_pass++;
    n_total++;
    if (busy_cycles != BUSY_CYC) $display("FAIL match_busy_cycles: got %0d want %0d", busy_cycles, BUSY_CYC);
    else n_pass++;
    for (int i = 0; i < BUSY_CYC; i++) begin
      n_total++;
      if (i >= trace.size() || trace[i] !== exp_vec[i / (SETTLE + 1)])
        $display("FAIL match_stim[%0d]: got %0d want %0d", i,
                 (i < trace.size()) ? trace[i] : 'x, exp_vec[i / (SETTLE + 1)]);
      else n_pass++;
    end
    n_total++;
    if ({done, pass} !== 2'b11) $display("FAIL match_done_pass: got %b%b want 11", done, pass);
    else n_pass++;
    n_total++;
    if (mismatch_count !== 16'd0 || vector_count !== 32'(NVEC))
      $display("FAIL match_counts: got mm=%0d vc=%0d want mm=0 vc=%0d", mismatch_count, vector_count, NVEC);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({done, busy, stim} !== {2'b10, exp_vec[NVEC-1]})
      $display("FAIL match_done_hold: got done=%b busy=%b stim=%0d want done=1 busy=0 stim=%0d",
               done, busy, stim, exp_vec[NVEC-1]);
    else n_pass++;
  endtask

  task automatic test_stuck();
    int emm, efirst; bit effv;
    mode = 1;
    model(1, 65535, emm, efirst, effv);
    do_run(1'b0);
    n_total++;
    if (mismatch_count !== 16'(emm) || pass !== 1'b0 || done !== 1'b1)
      $display("FAIL stuck_result: got mm=%0d pass=%b done=%b want mm=%0d pass=0 done=1",
               mismatch_count, pass, done, emm);
    else n_pass++;
    n_total++;
    if (first_fail_vec !== IN_W'(efirst) || first_fail_valid !== effv)
      $display("FAIL stuck_first: got vec=%0d valid=%b want vec=%0d valid=%b",
               first_fail_vec, first_fail_valid, efirst, effv);
    else n_pass++;
  endtask

  task automatic test_restart_in_done();
    mode = 0;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    do_run(1'b0);
    n_total++;
    if ({obs_done_first, obs_ffv_first} !== 2'b00 || obs_vc_first !== 32'd0 || obs_mm_first !== 16'd0)
      $display("FAIL restart_cleared: got done=%b ffv=%b vc=%0d mm=%0d want all 0",
               obs_done_first, obs_ffv_first, obs_vc_first, obs_mm_first);
    else n_pass++;
    n_total++;
    if (pass !== 1'b1 || vector_count !== 32'(NVEC) || busy_cycles != BUSY_CYC)
      $display("FAIL restart_result: got pass=%b vc=%0d cyc=%0d want pass=1 vc=%0d cyc=%0d",
               pass, vector_count, busy_cycles, NVEC, BUSY_CYC);
    else n_pass++;
  endtask

  task automatic test_single_fault();
    int emm, efirst; bit effv;
    mode = 2;
    model(2, 65535, emm, efirst, effv);
    do_run(1'b0);
    n_total++;
    if (mismatch_count !== 16'(emm) || first_fail_vec !== IN_W'(efirst) || pass !== 1'b0)
      $display("FAIL single_fault: got mm=%0d first=%0d pass=%b want mm=%0d first=%0d pass=0",
               mismatch_count, first_fail_vec, pass, emm, efirst);
    else n_pass++;
  endtask

  task automatic test_busy_start();
    mode = 0;
    do_run(1'b1);
    n_total++;
    if (busy_cycles != BUSY_CYC) $display("FAIL busy_start_cycles: got %0d want %0d", busy_cycles, BUSY_CYC);
    else n_pass++;
    for (int i = 0; i < BUSY_CYC; i++) begin
      n_total++;
      if (i >= trace.size() || trace[i] !== exp_vec[i / (SETTLE + 1)])
        $display("FAIL busy_start_stim[%0d]: got %0d want %0d", i,
                 (i < trace.size()) ? trace[i] : 'x, exp_vec[i / (SETTLE + 1)]);
      else n_pass++;
    end
    n_total++;
    if (pass !== 1'b1 || vector_count !== 32'(NVEC))
      $display("FAIL busy_start_result: got pass=%b vc=%0d want pass=1 vc=%0d", pass, vector_count, NVEC);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({stim, busy, done, pass, mismatch_count, vector_count, first_fail_vec, first_fail_valid} !== '0)
      $display("FAIL midrun_reset: got busy=%b mm=%0d vc=%0d ffv=%b want all 0",
               busy, mismatch_count, vector_count, first_fail_valid);
    else n_pass++;
    n_total++;
    if ({busy2, done2, mismatch_count2, vector_count2} !== '0)
      $display("FAIL midrun_reset_sat: got busy=%b mm=%0d vc=%0d want all 0", busy2, mismatch_count2, vector_count2);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    mode = 0;
    do_run(1'b0);
    n_total++;
    if (pass !== 1'b1 || vector_count !== 32'(NVEC) || busy_cycles != BUSY_CYC)
      $display("FAIL midrun_rerun: got pass=%b vc=%0d cyc=%0d want pass=1 vc=%0d cyc=%0d",
               pass, vector_count, busy_cycles, NVEC, BUSY_CYC);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int emm, efirst; bit effv;
    model(4, 3, emm, efirst, effv);
    do_run(1'b0);
    n_total++;
    if (mismatch_count2 !== 2'(emm) || vector_count2 !== 32'(NVEC) || pass2 !== 1'b0 || done2 !== 1'b1)
      $display("FAIL saturation: got mm=%0d vc=%0d pass=%b done=%b want mm=%0d vc=%0d pass=0 done=1",
               mismatch_count2, vector_count2, pass2, done2, emm, NVEC);
    else n_pass++;
    n_total++;
    if (first_fail_vec2 !== IN_W'(efirst) || first_fail_valid2 !== effv)
      $display("FAIL saturation_first: got vec=%0d valid=%b want vec=%0d valid=%b",
               first_fail_vec2, first_fail_valid2, efirst, effv);
    else n_pass++;
  endtask

  task automatic test_random_faults();
    int emm, efirst; bit effv;
    for (int it = 0; it < 8; it++) begin
      fault_map = 4'($urandom_range(0, 15));
      mode = 3;
      model(3, 65535, emm, efirst, effv);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_run(1'($urandom_range(0, 1)));
      n_total++;
      if (mismatch_count !== 16'(emm) || pass !== (emm == 0) || vector_count !== 32'(NVEC))
        $display("FAIL rand_result[map=%h]: got mm=%0d pass=%b vc=%0d want mm=%0d pass=%b vc=%0d",
                 fault_map, mismatch_count, pass, vector_count, emm, (emm == 0), NVEC);
      else n_pass++;
      n_total++;
      if (first_fail_valid !== effv || first_fail_vec !== IN_W'(efirst))
        $display("FAIL rand_first[map=%h]: got vec=%0d valid=%b want vec=%0d valid=%b",
                 fault_map, first_fail_vec, first_fail_valid, efirst, effv);
      else n_pass++;
      n_total++;
      if (busy_cycles != BUSY_CYC) $display("FAIL rand_cycles[map=%h]: got %0d want %0d", fault_map, busy_cycles, BUSY_CYC);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    fault_map = 4'h0;
    build_model();
    test_reset();
    test_match();
    test_stuck();
    test_restart_in_done();
    test_single_fault();
    test_busy_start();
    test_reset_midrun();
    test_saturation();
    test_random_faults();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
